// File: rtl/dispense_controller_if.sv
// Signal bundle between the dispense controller and its surroundings
// (user inputs, cup sensor, timing counter and status outputs).
interface dispense_controller_if #(
    parameter int BIT_COUNT   = 32,
    parameter int TOTAL_WIDTH = 16
);
    logic                   button;
    logic                   cup_present;
    logic [BIT_COUNT-1:0]   count;
    logic                   counter_reset;
    logic                   valve_open;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [TOTAL_WIDTH-1:0] dispense_total;

    // Environment side: drives the user inputs and the counter value
    modport master (
        output button,
        output cup_present,
        output count,
        input  counter_reset,
        input  valve_open,
        input  busy,
        input  done,
        input  aborted,
        input  dispense_total
    );

    // Controller side
    modport slave (
        input  button,
        input  cup_present,
        input  count,
        output counter_reset,
        output valve_open,
        output busy,
        output done,
        output aborted,
        output dispense_total
    );
endinterface

// File: rtl/dispense_controller.sv
// Dispense controller: a button press with a cup in place opens the valve
// for a fixed number of counter ticks. Removing the cup aborts the dispense.
// Completed dispenses are tallied in a saturating total.
module dispense_controller #(
    parameter int BIT_COUNT           = 32,
    parameter int CLOCK_PERIOD_IN_NS  = 20,
    parameter int DISPENSE_TIME_IN_NS = 360,
    parameter int TOTAL_WIDTH         = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    dispense_controller_if.slave bus
);

    // Valve-open time expressed in counter ticks
    localparam int TARGET_COUNT = DISPENSE_TIME_IN_NS / CLOCK_PERIOD_IN_NS;
    localparam logic [BIT_COUNT-1:0] TARGET_COUNT_EXT = BIT_COUNT'(TARGET_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_DONE     = 3'd3,
        ST_ABORT    = 3'd4
    } state_t;

    // Increment that holds at all-ones instead of wrapping
    function automatic logic [TOTAL_WIDTH-1:0] sat_inc(input logic [TOTAL_WIDTH-1:0] value);
        logic [TOTAL_WIDTH-1:0] result;
        if (value == {TOTAL_WIDTH{1'b1}}) begin
            result = value;
        end else begin
            result = value + TOTAL_WIDTH'(1);
        end
        return result;
    endfunction

    // Synchroniser and edge-detect registers
    logic btn_meta_r;
    logic btn_sync_r;
    logic btn_prev_r;
    logic cup_meta_r;
    logic cup_sync_r;

    // FSM and tally
    state_t                 state_r;
    state_t                 state_next_s;
    logic [TOTAL_WIDTH-1:0] total_r;
    logic [TOTAL_WIDTH-1:0] total_next_s;
    logic                   press_s;
    logic                   target_reached_s;

    // Registered outputs
    logic counter_reset_r;
    logic valve_open_r;
    logic busy_r;
    logic done_r;
    logic aborted_r;

    assign press_s          = btn_sync_r & ~btn_prev_r;
    assign target_reached_s = (bus.count >= TARGET_COUNT_EXT);

    // Two-flop synchronisers for the asynchronous inputs plus the button edge register
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            btn_prev_r <= 1'b0;
            cup_meta_r <= 1'b0;
            cup_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= bus.button;
            btn_sync_r <= btn_meta_r;
            btn_prev_r <= btn_sync_r;
            cup_meta_r <= bus.cup_present;
            cup_sync_r <= cup_meta_r;
        end
    end

    // Next-state selection and tally update; count matters only while dispensing
    always_comb begin
        state_next_s = ST_IDLE;
        total_next_s = total_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s && cup_sync_r) begin
                    state_next_s = ST_ARM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                state_next_s = ST_DISPENSE;
            end
            ST_DISPENSE: begin
                if (!cup_sync_r) begin
                    state_next_s = ST_ABORT;
                end else if (target_reached_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DISPENSE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                total_next_s = sat_inc(total_r);
            end
            ST_ABORT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset overrides any dispense in progress
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Completed-dispense tally
    always_ff @(posedge clock) begin
        if (!reset) begin
            total_r <= '0;
        end else begin
            total_r <= total_next_s;
        end
    end

    // Moore outputs registered from the next state so they track state_r exactly
    always_ff @(posedge clock) begin
        if (!reset) begin
            counter_reset_r <= 1'b0;
            valve_open_r    <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            aborted_r       <= 1'b0;
        end else begin
            counter_reset_r <= (state_next_s == ST_ARM);
            valve_open_r    <= (state_next_s == ST_DISPENSE);
            busy_r          <= (state_next_s != ST_IDLE);
            done_r          <= (state_next_s == ST_DONE);
            aborted_r       <= (state_next_s == ST_ABORT);
        end
    end

    assign bus.counter_reset  = counter_reset_r;
    assign bus.valve_open     = valve_open_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.aborted        = aborted_r;
    assign bus.dispense_total = total_r;

endmodule
